// File: rtl/adc_pwm_multi_if.sv
// Bus between the multi-channel ADC sampler/PWM block and its surroundings:
// ADC serial pins, enable, captured samples and PWM outputs.
interface adc_pwm_multi_if #(
  parameter int unsigned CH = 2,
  parameter int unsigned DW = 12
);
  logic                enable;
  logic [CH-1:0]       sdata;
  logic                sclk;
  logic                cs;
  logic                sample_valid;
  logic [CH*DW-1:0]    sample_data;
  logic [CH-1:0]       pwm;

  modport master (
    input  enable, sdata,
    output sclk, cs, sample_valid, sample_data, pwm
  );

  modport slave (
    output enable, sdata,
    input  sclk, cs, sample_valid, sample_data, pwm
  );
endinterface

// File: rtl/adc_pwm_multi.sv
// Shared-cs/sclk serial ADC reader for CH channels feeding one PWM output per
// channel; duty cycles follow the captured samples, updated only at counter wrap.
module adc_pwm_multi #(
  parameter int unsigned CH       = 2,
  parameter int unsigned DW       = 12,
  parameter int unsigned FRAME    = 16,
  parameter int unsigned SCLK_DIV = 4,
  parameter int unsigned QUIET    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  adc_pwm_multi_if.master  bus
);

  localparam int unsigned HALF  = SCLK_DIV / 2;
  localparam int unsigned DIV_W = $clog2(SCLK_DIV);
  localparam int unsigned BIT_W = $clog2(FRAME + 1);
  localparam int unsigned QW    = (QUIET > 1) ? $clog2(QUIET) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_QUIET = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [QW-1:0]          quiet_q, quiet_d;
  logic                   cs_q, cs_d;
  logic                   sclk_q, sclk_d;
  logic                   valid_q, valid_d;
  logic [CH-1:0][DW-1:0]  shift_q, shift_d;
  logic [CH-1:0][DW-1:0]  data_q, data_d;
  logic [DW-1:0]          cnt_q, cnt_d;
  logic [CH-1:0][DW-1:0]  duty_q, duty_d;
  logic [CH-1:0]          pwm_q, pwm_d;

  // Frame sequencer. Each sclk period is a high half then a low half, so the
  // FRAME-th rising edge lands on bit_q == FRAME with div_q == 0.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    quiet_d = quiet_q;
    cs_d    = 1'b1;
    sclk_d  = 1'b1;
    valid_d = 1'b0;
    shift_d = shift_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          state_d = S_CONV;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      S_CONV: begin
        cs_d   = 1'b0;
        sclk_d = (div_q < DIV_W'(HALF));
        if (div_q == '0 && bit_q != '0) begin
          for (int k = 0; k < int'(CH); k++) begin
            shift_d[k] = {shift_q[k][DW-2:0], bus.sdata[k]};
          end
        end
        if (bit_q == BIT_W'(FRAME)) begin
          state_d = S_QUIET;
          quiet_d = '0;
          div_d   = '0;
          bit_d   = '0;
        end else if (div_q == DIV_W'(SCLK_DIV - 1)) begin
          div_d = '0;
          bit_d = bit_q + 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_QUIET: begin
        if (quiet_q == '0) begin
          valid_d = 1'b1;
          data_d  = shift_q;
        end
        if (quiet_q == QW'(QUIET - 1)) begin
          state_d = bus.enable ? S_CONV : S_IDLE;
        end else begin
          quiet_d = quiet_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // PWM compare uses next counter/duty so pwm_q always matches cnt_q < duty_q.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    duty_d = duty_q;
    pwm_d  = '0;
    if (cnt_q == '1) duty_d = data_q;
    for (int k = 0; k < int'(CH); k++) begin
      pwm_d[k] = (cnt_d < duty_d[k]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      quiet_q <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      valid_q <= 1'b0;
      shift_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      duty_q  <= '0;
      pwm_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      quiet_q <= quiet_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      valid_q <= valid_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
    end
  end

  assign bus.cs           = cs_q;
  assign bus.sclk         = sclk_q;
  assign bus.sample_valid = valid_q;
  assign bus.sample_data  = data_q;
  assign bus.pwm          = pwm_q;

endmodule

// File: tb/tb_adc_pwm_multi.sv
// Bench for adc_pwm_multi: serial ADC model, frame timing monitor and
// per-period PWM high-time counting against the samples the ADC returned.
module tb_adc_pwm_multi;

  localparam int unsigned CH       = 2;
  localparam int unsigned DW       = 12;
  localparam int unsigned FRAME    = 16;
  localparam int unsigned SCLK_DIV = 4;
  localparam int unsigned QUIET    = 4;
  localparam int unsigned PER      = 1 << DW;

  logic              clk;
  logic              rst_n;
  int                checks = 0;
  int                errors = 0;
  int unsigned       tb_cyc;
  logic [FRAME-1:0]  adc_word   [CH];
  logic [FRAME-1:0]  adc_shadow [CH];
  int                adc_bit;

  adc_pwm_multi_if #(.CH(CH), .DW(DW)) bus ();

  adc_pwm_multi #(
    .CH(CH), .DW(DW), .FRAME(FRAME), .SCLK_DIV(SCLK_DIV), .QUIET(QUIET)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clocks since reset release; the PWM period starts whenever this is a multiple of PER.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;

  // ADC: latch the word at the first falling sclk, present next bit after every fall.
  always @(negedge bus.sclk or posedge bus.cs) begin
    if (bus.cs) adc_bit = 0;
    else if (adc_bit < int'(FRAME)) begin
      if (adc_bit == 0)
        for (int k = 0; k < int'(CH); k++) adc_shadow[k] = adc_word[k];
      for (int k = 0; k < int'(CH); k++)
        bus.sdata[k] = adc_shadow[k][int'(FRAME) - 1 - adc_bit];
      adc_bit++;
    end
  end

  function automatic logic [CH*DW-1:0] exp_data();
    logic [CH*DW-1:0] e;
    e = '0;
    for (int k = 0; k < int'(CH); k++) e[k*DW +: DW] = adc_word[k][DW-1:0];
    return e;
  endfunction

  task automatic watch_frame(input int budget, output bit got, output int falls,
                             output int bad_per, output int sclk_bad,
                             output int nz_before, output logic [CH*DW-1:0] data);
    logic prev;
    int   last;
    got = 1'b0; falls = 0; bad_per = 0; sclk_bad = 0; nz_before = 0; data = '0;
    prev = bus.sclk; last = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.cs && !bus.sclk) sclk_bad++;
      if (prev && !bus.sclk && !bus.cs) begin
        if (last >= 0 && (i - last) != int'(SCLK_DIV)) bad_per++;
        last = i;
        falls++;
      end
      prev = bus.sclk;
      if (bus.sample_valid) begin
        got  = 1'b1;
        data = bus.sample_data;
        break;
      end
      if (bus.sample_data != '0) nz_before++;
    end
  endtask

  task automatic measure_quiet(output int hi, output int extra_valid);
    hi = 1; extra_valid = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.cs) break;
      hi++;
      if (bus.sample_valid) extra_valid++;
    end
  endtask

  task automatic wait_falls(input int n_want, output int n);
    logic prev;
    n = 0; prev = bus.sclk;
    for (int i = 0; i < 300 && n < n_want; i++) begin
      @(negedge clk);
      if (prev && !bus.sclk) n++;
      prev = bus.sclk;
    end
  endtask

  task automatic capture(input logic [FRAME-1:0] w0, input logic [FRAME-1:0] w1,
                         output bit ok, output logic [CH*DW-1:0] data);
    int n, falls, bp, sb, nz;
    adc_word[0] = w0;
    adc_word[1] = w1;
    bus.enable = 1'b1;
    ok = 1'b0; data = '0;
    wait_falls(5, n);
    bus.enable = 1'b0;
    if (n == 5) watch_frame(200, ok, falls, bp, sb, nz, data);
  endtask

  task automatic align_wrap();
    for (int i = 0; i <= int'(PER) && (tb_cyc % PER) != 0; i++) @(negedge clk);
  endtask

  task automatic measure_pwm(output int hi0, output int hi1);
    hi0 = 0; hi1 = 0;
    align_wrap();
    for (int i = 0; i < int'(PER); i++) begin
      hi0 += int'(bus.pwm[0]);
      hi1 += int'(bus.pwm[1]);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enable = 1'b0;
    for (int k = 0; k < int'(CH); k++) adc_word[k] = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.cs !== 1'b1) begin errors++; $display("FAIL reset_cs got %b exp 1", bus.cs); end
    checks++; if (bus.sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk got %b exp 1", bus.sclk); end
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.sample_valid); end
    checks++; if (bus.sample_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.sample_data); end
    checks++; if (bus.pwm !== '0) begin errors++; $display("FAIL reset_pwm got %b exp 0", bus.pwm); end
  endtask

  task automatic test_first_cs();
    adc_word[0] = FRAME'(16'h0ABC);
    adc_word[1] = FRAME'(16'h0123);
    bus.enable = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.cs !== 1'b1) begin errors++; $display("FAIL cs_edge1 got %b exp 1", bus.cs); end
    @(posedge clk); #1;
    checks++; if (bus.cs !== 1'b0) begin errors++; $display("FAIL cs_edge2 got %b exp 0", bus.cs); end
  endtask

  task automatic test_frame();
    bit got; int falls, bp, sb, nz, hi, ev;
    logic [CH*DW-1:0] d;
    watch_frame(200, got, falls, bp, sb, nz, d);
    checks++; if (!got) begin errors++; $display("FAIL frame_valid got 0 exp 1"); end
    checks++; if (falls != int'(FRAME)) begin errors++; $display("FAIL frame_falls got %0d exp %0d", falls, FRAME); end
    checks++; if (bp != 0) begin errors++; $display("FAIL sclk_period bad periods %0d exp 0", bp); end
    checks++; if (sb != 0) begin errors++; $display("FAIL sclk_idle low-with-cs-high %0d exp 0", sb); end
    checks++; if (d !== {12'h123, 12'hABC}) begin errors++; $display("FAIL frame_data got %h exp %h", d, {12'h123, 12'hABC}); end
    for (int k = 0; k < int'(CH); k++) adc_word[k] = FRAME'($urandom);
    measure_quiet(hi, ev);
    checks++; if (hi != int'(QUIET)) begin errors++; $display("FAIL quiet_len got %0d exp %0d", hi, QUIET); end
    checks++; if (ev != 0) begin errors++; $display("FAIL valid_width extra %0d exp 0", ev); end
  endtask

  task automatic test_back_to_back();
    bit got; int falls, bp, sb, nz, hi, ev;
    logic [CH*DW-1:0] d, e;
    for (int f = 0; f < 6; f++) begin
      e = exp_data();
      watch_frame(200, got, falls, bp, sb, nz, d);
      checks++; if (!got || falls != int'(FRAME) || bp != 0 || sb != 0) begin
        errors++; $display("FAIL b2b_timing frame %0d got valid=%0d falls=%0d badper=%0d exp 1/%0d/0", f, got, falls, bp, FRAME);
      end
      checks++; if (d !== e) begin errors++; $display("FAIL b2b_data frame %0d got %h exp %h", f, d, e); end
      for (int k = 0; k < int'(CH); k++) adc_word[k] = FRAME'($urandom);
      measure_quiet(hi, ev);
      checks++; if (hi != int'(QUIET) || ev != 0) begin
        errors++; $display("FAIL b2b_quiet frame %0d got %0d extra %0d exp %0d", f, hi, ev, QUIET);
      end
    end
  endtask

  task automatic test_enable_drop();
    bit ok; int lo, v, sl;
    logic [CH*DW-1:0] d;
    capture(FRAME'($urandom), FRAME'($urandom), ok, d);
    checks++; if (!ok) begin errors++; $display("FAIL drop_valid got 0 exp 1"); end
    checks++; if (d !== exp_data()) begin errors++; $display("FAIL drop_data got %h exp %h", d, exp_data()); end
    lo = 0; v = 0; sl = 0;
    repeat (300) begin
      @(negedge clk);
      if (!bus.cs) lo++;
      if (!bus.sclk) sl++;
      if (bus.sample_valid) v++;
    end
    checks++; if (lo != 0 || v != 0 || sl != 0) begin
      errors++; $display("FAIL drop_idle cs_low %0d sclk_low %0d valids %0d exp 0", lo, sl, v);
    end
  endtask

  task automatic test_pwm_extremes();
    bit ok; int h0, h1;
    logic [CH*DW-1:0] d;
    logic [FRAME-1:0] w0, w1;
    w0 = FRAME'($urandom); w0[DW-1:0] = '0; w1 = FRAME'($urandom);
    capture(w0, w1, ok, d);
    measure_pwm(h0, h1);
    checks++; if (!ok || h0 != 0) begin errors++; $display("FAIL pwm_zero valid=%0d high %0d exp 0", ok, h0); end
    checks++; if (h1 != int'(w1[DW-1:0])) begin errors++; $display("FAIL pwm_ch1_a high %0d exp %0d", h1, w1[DW-1:0]); end
    w0 = FRAME'($urandom); w0[DW-1:0] = '1; w1 = FRAME'($urandom);
    capture(w0, w1, ok, d);
    measure_pwm(h0, h1);
    checks++; if (!ok || h0 != int'(PER) - 1) begin errors++; $display("FAIL pwm_full valid=%0d high %0d exp %0d", ok, h0, PER - 1); end
    checks++; if (h1 != int'(w1[DW-1:0])) begin errors++; $display("FAIL pwm_ch1_b high %0d exp %0d", h1, w1[DW-1:0]); end
  endtask

  task automatic test_pwm_mid_period();
    int h0, h1, v, old1;
    logic [FRAME-1:0] w0, w1;
    old1 = int'(adc_word[1][DW-1:0]);
    w0 = FRAME'($urandom); w0[DW-1:0] = DW'(12'h800); w1 = FRAME'($urandom);
    adc_word[0] = w0; adc_word[1] = w1;
    align_wrap();
    h0 = 0; h1 = 0; v = 0;
    for (int i = 0; i < int'(PER); i++) begin
      if (i == 1000) bus.enable = 1'b1;
      if (i == 1010) bus.enable = 1'b0;
      h0 += int'(bus.pwm[0]);
      h1 += int'(bus.pwm[1]);
      if (bus.sample_valid) v++;
      @(negedge clk);
    end
    checks++; if (v != 1) begin errors++; $display("FAIL mid_valid count %0d exp 1", v); end
    checks++; if (h0 != int'(PER) - 1 || h1 != old1) begin
      errors++; $display("FAIL mid_hold high %0d/%0d exp %0d/%0d", h0, h1, PER - 1, old1);
    end
    measure_pwm(h0, h1);
    checks++; if (h0 != 2048 || h1 != int'(w1[DW-1:0])) begin
      errors++; $display("FAIL mid_new high %0d/%0d exp 2048/%0d", h0, h1, w1[DW-1:0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit got; int n, falls, bp, sb, nz, v;
    logic [CH*DW-1:0] d;
    for (int k = 0; k < int'(CH); k++) adc_word[k] = FRAME'($urandom);
    bus.enable = 1'b1;
    wait_falls(8, n);
    checks++; if (n != 8) begin errors++; $display("FAIL rst_mid_reach falls %0d exp 8", n); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.cs !== 1'b1 || bus.sclk !== 1'b1) begin
      errors++; $display("FAIL rst_mid_async cs %b sclk %b exp 1 1", bus.cs, bus.sclk);
    end
    checks++; if (bus.sample_data !== '0 || bus.sample_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_clear data %h valid %b exp 0 0", bus.sample_data, bus.sample_valid);
    end
    v = 0;
    repeat (4) begin @(negedge clk); if (bus.sample_valid) v++; end
    checks++; if (v != 0) begin errors++; $display("FAIL rst_mid_novalid count %0d exp 0", v); end
    for (int k = 0; k < int'(CH); k++) adc_word[k] = FRAME'($urandom);
    rst_n = 1'b1;
    watch_frame(200, got, falls, bp, sb, nz, d);
    checks++; if (!got || falls != int'(FRAME) || nz != 0) begin
      errors++; $display("FAIL rst_mid_frame valid=%0d falls=%0d early_data=%0d exp 1/%0d/0", got, falls, nz, FRAME);
    end
    checks++; if (d !== exp_data()) begin errors++; $display("FAIL rst_mid_data got %h exp %h", d, exp_data()); end
  endtask

  initial begin
    test_reset();
    test_first_cs();
    test_frame();
    test_back_to_back();
    test_enable_drop();
    test_pwm_extremes();
    test_pwm_mid_period();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_pwm_multi.md
ADC_PWM_MULTI -- requirements
Module: adc_pwm_multi

Interface
REQ-001 Parameter CH, default 2: number of ADC channels sharing one cs/sclk, range 1..4.
REQ-002 Parameter DW, default 12: ADC sample width and PWM resolution, range 8..16.
REQ-003 Parameter FRAME, default 16: sclk cycles per conversion frame, FRAME >= DW.
REQ-004 Parameter SCLK_DIV, default 4: clk cycles per sclk period, even, >= 2.
REQ-005 Parameter QUIET, default 4: minimum clk cycles cs stays high between frames, >= 1.
REQ-006 clk  input  1  single system clock, all logic on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  high = run continuous conversions; low = stop after current frame.
REQ-009 sdata  input  CH  serial data per channel, MSB first, driven by ADC after falling sclk.
REQ-010 sclk  output  1  ADC serial clock, idle high.
REQ-011 cs  output  1  ADC chip select, active low.
REQ-012 sample_valid  output  1  one-clk pulse when a new frame is captured.
REQ-013 sample_data  output  CH*DW  latest samples, channel k at bits [k*DW+DW-1 : k*DW].
REQ-014 pwm  output  CH  PWM per channel, duty = captured sample of that channel.

Function
REQ-015 FSM states IDLE, CONV, QUIET; all outputs registered.
REQ-016 IDLE: cs=1, sclk=1; enable=1 -> CONV on next clk.
REQ-017 CONV: cs=0; sclk low for SCLK_DIV/2 clk, high for SCLK_DIV/2 clk, FRAME periods; first falling sclk SCLK_DIV/2 clk after cs falls.
REQ-018 Each channel shift register samples sdata[k] on the clk where sclk rises, shifting left, MSB first.
REQ-019 After the FRAME-th rising sclk edge: cs=1 on next clk, state -> QUIET, sample_data[k] <= last DW bits shifted (leading FRAME-DW bits discarded), sample_valid=1 for exactly that clk.
REQ-020 QUIET: cs=1, sclk=1 for QUIET clk; then -> CONV if enable=1, else IDLE.
REQ-021 enable falling during CONV does not truncate the frame; frame completes and is delivered.
REQ-022 PWM counter: one shared DW-bit free-running counter, increments every clk, wraps 2^DW-1 -> 0.
REQ-023 Per-channel duty register loads from sample_data only on the clk the counter wraps to 0; no mid-period duty change.
REQ-024 pwm[k] = 1 when counter < duty[k]; duty 0 -> constant 0; duty 2^DW-1 -> high 2^DW-1 of 2^DW clk.
REQ-025 sample_valid and duty update on the same clk: duty loads the previous sample_data; new value applies at next wrap.
REQ-026 Frame sclk period count and bit count wrap-safe: counters sized ceil(log2(FRAME+1)) and ceil(log2(SCLK_DIV)).

Reset
REQ-027 reset=0 asynchronously forces: state IDLE, cs=1, sclk=1, sample_valid=0, sample_data=0, shift registers=0, duty=0, PWM counter=0, pwm=0.
REQ-028 reset asserted mid-CONV aborts the frame; no sample_valid; partial bits discarded.
REQ-029 After reset release with enable=1, first cs fall occurs on the second rising clk.

Verification
REQ-030 Defaults, enable=1, ADC model returns 16-bit frames 0x0ABC (ch0), 0x0123 (ch1) shifted on falling sclk -> after 16 sclk periods sample_valid pulses once, sample_data = {12'h123,12'hABC}, cs high >= 4 clk.
REQ-031 Measure sclk: period = 4 clk, exactly 16 falling edges per cs-low window, sclk=1 whenever cs=1.
REQ-032 Sample 0x000 on ch0 -> pwm[0] constant 0; sample 0xFFF -> pwm[0] high 4095 of 4096 clk after next counter wrap.
REQ-033 Sample 0x800 captured mid-PWM-period -> pwm[0] duty unchanged until counter wraps, then exactly 2048 high clk per 4096.
REQ-034 Drop enable after 5th sclk edge -> frame completes, sample_valid pulses, then IDLE with cs=1, no further frames.
REQ-035 Assert reset during 8th sclk period -> cs=1, sclk=1 immediately (no clk edge), sample_valid never pulses, sample_data stays 0; after release, fresh full frame captured correctly.
